ir_nec_tx: RTL
==============

IR_NEC_TX -- requirements
Module: ir_nec_tx

Interface
REQ-001 TICK_DIV, default 48, clk cycles per 1 us timing tick (1..65535).
REQ-002 CARRIER_HALF, default 624, clk cycles per carrier half-period (48 MHz -> ~38.46 kHz).
REQ-003 GAP_US, default 40000, idle time in us after the stop mark before a new frame is accepted.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 address  input  8  NEC address byte, sampled on accepted send.
REQ-007 command  input  8  NEC command byte, sampled on accepted send.
REQ-008 send  input  1  frame request, level-sampled each clk.
REQ-009 ir  output  1  baseband line, idle high, low during marks, registered.
REQ-010 ir_carrier  output  1  modulated line, carrier during marks, low otherwise, registered.
REQ-011 busy  output  1  high from accepted send until the GAP phase ends.
REQ-012 done  output  1  one-clk pulse when the stop mark ends.

Function
REQ-013 A send SHALL be accepted only when state is IDLE and send=1; address and command are latched in that cycle.
REQ-014 send while busy SHALL be ignored; no queuing.
REQ-015 Frame word = {~command, command, ~address, address}; bits SHALL be transmitted LSB first, bit 0 = address[0].
REQ-016 States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-017 Durations in ticks: LEAD_MARK 9000, LEAD_SPACE 4500, BIT_MARK 560, BIT_SPACE 560 for a 0 and 1690 for a 1, STOP_MARK 560, GAP GAP_US.
REQ-018 The tick prescaler and duration counter SHALL restart on acceptance, so each phase lasts exactly duration*TICK_DIV clk cycles.
REQ-019 ir SHALL go low on the clk edge after acceptance; busy rises on the same edge.
REQ-020 Transitions on phase expiry: LEAD_MARK->LEAD_SPACE->BIT_MARK; BIT_MARK->BIT_SPACE; BIT_SPACE->BIT_MARK while bits remain, else ->STOP_MARK; STOP_MARK->GAP; GAP->IDLE.
REQ-021 The bit counter SHALL be 6 bits; the 32nd BIT_SPACE SHALL lead to STOP_MARK with no wrap.
REQ-022 ir SHALL be 0 in LEAD_MARK, BIT_MARK and STOP_MARK, and 1 in all other states.
REQ-023 ir_carrier SHALL be 1 at the first cycle of every mark and toggle every CARRIER_HALF clks within that mark.
REQ-024 ir_carrier SHALL be forced to 0 in all non-mark states; the carrier counter restarts at each mark start.
REQ-025 done SHALL pulse for exactly one clk, on the STOP_MARK->GAP transition.
REQ-026 busy SHALL fall on the GAP->IDLE transition.
REQ-027 A send=1 in that same cycle SHALL NOT be accepted; acceptance is possible from the next clk.
REQ-028 The duration counter SHALL be 16 bits and never wrap; parameters exceeding 65535 ticks are illegal.

Reset
REQ-029 rst=1 SHALL force: state IDLE, ir=1, ir_carrier=0, busy=0, done=0, all counters 0, latched data 0.
REQ-030 rst mid-frame SHALL abort immediately with no done pulse.
REQ-031 rst=1 SHALL override a simultaneous send.

Verification
REQ-032 Nominal frame, TICK_DIV=2, CARRIER_HALF=26, GAP_US=40000; address=0x00, command=0x45, send pulse -> ir low 18000 clks, high 9000; bits 0x00/0xFF/0x45/0xBA LSB first (16 ones, 16 zeros); done exactly 135960 clks after acceptance; busy falls 80000 clks later.
REQ-033 Carrier: during the 9000-tick lead mark ir_carrier toggles every 26 clks, starting high; ir_carrier=0 throughout every space and the gap.
REQ-034 Busy rejection: second send mid-frame with address=0xFF -> frame unchanged, exactly one done.
REQ-035 Gap boundary: send held high continuously -> the next frame starts one clk after busy falls; inter-frame idle is exactly GAP_US*TICK_DIV+1 clks of ir high after the stop mark.
REQ-036 Reset mid-frame: rst during bit 10 -> next clk ir=1, ir_carrier=0, busy=0, no done; a following send produces a complete frame.
REQ-037 Loopback: connect ir to the IR receiver, address=0x00, command=0x16 -> receiver code output equals 0x16.

Source files
------------

// File: rtl/ir_nec_tx.sv
// rtl/ir_nec_tx.sv - NEC infrared frame transmitter with baseband and carrier outputs
module ir_nec_tx #(
  parameter int TICK_DIV     = 48,
  parameter int CARRIER_HALF = 624,
  parameter int GAP_US       = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] command,
  input  logic       send,
  output logic       ir,
  output logic       ir_carrier,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] CAR_LAST  = 16'(CARRIER_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_US - 1);

  state_t      state, state_nx;
  logic [15:0] presc;
  logic [15:0] dur;
  logic [15:0] dur_last;
  logic [15:0] car_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] frame;
  logic        tick;
  logic        expire;
  logic        accept;
  logic        mark_cur;
  logic        mark_nx;
  logic        done_nx;

  // Last tick index of the current phase; a BIT_SPACE length follows the bit being sent.
  always_comb begin
    dur_last = 16'd0;
    case (state)
      LEAD_MARK:           dur_last = 16'd8999;
      LEAD_SPACE:          dur_last = 16'd4499;
      BIT_MARK, STOP_MARK: dur_last = 16'd559;
      BIT_SPACE:           dur_last = frame[0] ? 16'd1689 : 16'd559;
      GAP:                 dur_last = GAP_LAST;
      default:             dur_last = 16'd0;
    endcase
  end

  assign tick   = (presc == TICK_LAST);
  assign expire = tick && (dur == dur_last);
  assign accept = (state == IDLE) && send;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:       if (send)   state_nx = LEAD_MARK;
      LEAD_MARK:  if (expire) state_nx = LEAD_SPACE;
      LEAD_SPACE: if (expire) state_nx = BIT_MARK;
      BIT_MARK:   if (expire) state_nx = BIT_SPACE;
      BIT_SPACE:  if (expire) state_nx = (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK: begin
        if (expire) begin
          state_nx = GAP;
          done_nx  = 1'b1;
        end
      end
      GAP:        if (expire) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  assign mark_cur = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
  assign mark_nx  = (state_nx == LEAD_MARK) || (state_nx == BIT_MARK) || (state_nx == STOP_MARK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= 1'b1;
      ir_carrier <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      presc      <= 16'd0;
      dur        <= 16'd0;
      car_cnt    <= 16'd0;
      bit_cnt    <= 6'd0;
      frame      <= 32'd0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      busy  <= (state_nx != IDLE);
      ir    <= ~mark_nx;

      if (accept) begin
        frame   <= {~command, command, ~address, address};
        bit_cnt <= 6'd0;
      end else if ((state == BIT_SPACE) && expire) begin
        frame   <= frame >> 1;
        bit_cnt <= bit_cnt + 6'd1;
      end

      // Every phase starts from a clean prescaler so its length is exact in clk cycles.
      if (accept || expire) begin
        presc <= 16'd0;
        dur   <= 16'd0;
      end else if (state != IDLE) begin
        if (tick) begin
          presc <= 16'd0;
          dur   <= dur + 16'd1;
        end else begin
          presc <= presc + 16'd1;
        end
      end

      if (!mark_nx) begin
        ir_carrier <= 1'b0;
        car_cnt    <= 16'd0;
      end else if (!mark_cur) begin
        ir_carrier <= 1'b1;
        car_cnt    <= 16'd0;
      end else if (car_cnt == CAR_LAST) begin
        ir_carrier <= ~ir_carrier;
        car_cnt    <= 16'd0;
      end else begin
        car_cnt <= car_cnt + 16'd1;
      end
    end
  end

endmodule
